// File: rtl/core_pkg.sv
// Shared encodings for core_mc: opcodes, function codes, FSM states and ALU operations.
package core_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RFLD_W  = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_IN    = 6'h3c;
    localparam logic [5:0] OP_OUT   = 6'h3d;

    localparam logic [5:0] FUN_SLL  = 6'h00;
    localparam logic [5:0] FUN_SRL  = 6'h02;
    localparam logic [5:0] FUN_JR   = 6'h08;
    localparam logic [5:0] FUN_JALR = 6'h09;
    localparam logic [5:0] FUN_ADD  = 6'h20;
    localparam logic [5:0] FUN_SUB  = 6'h22;
    localparam logic [5:0] FUN_AND  = 6'h24;
    localparam logic [5:0] FUN_OR   = 6'h25;
    localparam logic [5:0] FUN_NOR  = 6'h27;
    localparam logic [5:0] FUN_SLT  = 6'h2a;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_IN_WAIT,
        S_OUT_WAIT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_t;

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU; shifts operate on b (the r_t operand).
module core_alu
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      shamt,
    output logic [XLEN-1:0] result
);

    // Operation select; arithmetic wraps at XLEN bits
    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = XLEN'($signed(a) < $signed(b));
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_LUI: result = b << 16;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/core_mc.sv
// Multi-cycle integer core: FETCH/EXEC with memory and byte-IO wait states.
module core_mc
    import core_pkg::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NREG    = 32,
    parameter int unsigned     IADDR_W = 12,
    parameter int unsigned     DADDR_W = 12,
    parameter logic [XLEN-1:0] SP_INIT = '0,
    parameter logic [XLEN-1:0] FP_INIT = XLEN'(32'h40)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               running,
    output logic [IADDR_W-1:0] pc_dbg
);

    localparam int unsigned RIDX_W = $clog2(NREG);

    state_t             state, state_n;
    logic [IADDR_W-1:0] pc, pc_n, pc_inc;
    logic [RIDX_W-1:0]  rt_q, rt_n;
    logic [XLEN-1:0]    regs [NREG];

    logic               dmem_req_n, dmem_we_n, in_ready_n, out_valid_n, running_n;
    logic [DADDR_W-1:0] dmem_addr_n;
    logic [XLEN-1:0]    dmem_wdata_n;
    logic [7:0]         out_data_n;

    logic               wr_en;
    logic [RIDX_W-1:0]  wr_idx;
    logic [XLEN-1:0]    wr_data;
    alu_op_t            alu_op;
    logic [XLEN-1:0]    alu_b, alu_res;

    logic [5:0]         op_f, funct_f;
    logic [4:0]         rs_f, rt_f, rd_f, shamt_f;
    logic [15:0]        imm_f;
    logic [25:0]        target_f;
    logic [XLEN-1:0]    rs_val, rt_val, imm_sext, imm_zext;

    // Instruction field split and operand read
    assign op_f     = imem_rdata[31:26];
    assign rs_f     = imem_rdata[25:21];
    assign rt_f     = imem_rdata[20:16];
    assign rd_f     = imem_rdata[15:11];
    assign shamt_f  = imem_rdata[10:6];
    assign funct_f  = imem_rdata[5:0];
    assign imm_f    = imem_rdata[15:0];
    assign target_f = imem_rdata[25:0];
    assign imm_sext = {{(XLEN-16){imm_f[15]}}, imm_f};
    assign imm_zext = {{(XLEN-16){1'b0}}, imm_f};
    assign rs_val   = regs[RIDX_W'(rs_f)];
    assign rt_val   = regs[RIDX_W'(rt_f)];
    assign pc_inc   = pc + IADDR_W'(1);

    assign imem_addr = pc;
    assign pc_dbg    = pc;

    core_alu #(.XLEN(XLEN)) u_alu (
        .op     (alu_op),
        .a      (rs_val),
        .b      (alu_b),
        .shamt  (shamt_f),
        .result (alu_res)
    );

    // Next-state, register write-back and registered-output next values
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        rt_n         = rt_q;
        wr_en        = 1'b0;
        wr_idx       = RIDX_W'(rt_f);
        wr_data      = alu_res;
        alu_op       = ALU_ADD;
        alu_b        = rt_val;
        dmem_req_n   = dmem_req;
        dmem_we_n    = dmem_we;
        dmem_addr_n  = dmem_addr;
        dmem_wdata_n = dmem_wdata;
        in_ready_n   = in_ready;
        out_valid_n  = out_valid;
        out_data_n   = out_data;

        unique case (state)
            S_IDLE: begin
                if (START) state_n = S_FETCH;
            end
            S_FETCH: state_n = S_EXEC;
            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc;
                case (op_f)
                    OP_RTYPE: begin
                        wr_idx = RIDX_W'(rd_f);
                        case (funct_f)
                            FUN_ADD: begin alu_op = ALU_ADD; wr_en = 1'b1; end
                            FUN_SUB: begin alu_op = ALU_SUB; wr_en = 1'b1; end
                            FUN_AND: begin alu_op = ALU_AND; wr_en = 1'b1; end
                            FUN_OR:  begin alu_op = ALU_OR;  wr_en = 1'b1; end
                            FUN_NOR: begin alu_op = ALU_NOR; wr_en = 1'b1; end
                            FUN_SLT: begin alu_op = ALU_SLT; wr_en = 1'b1; end
                            FUN_SLL: begin alu_op = ALU_SLL; wr_en = 1'b1; end
                            FUN_SRL: begin alu_op = ALU_SRL; wr_en = 1'b1; end
                            FUN_JR:  pc_n = IADDR_W'(rs_val);
                            FUN_JALR: begin
                                pc_n    = IADDR_W'(rs_val);
                                wr_en   = 1'b1;
                                wr_idx  = RIDX_W'(31);
                                wr_data = XLEN'(pc_inc);
                            end
                            default: ;
                        endcase
                    end
                    OP_ADDI: begin alu_op = ALU_ADD; alu_b = imm_sext; wr_en = 1'b1; end
                    OP_SLTI: begin alu_op = ALU_SLT; alu_b = imm_sext; wr_en = 1'b1; end
                    OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zext; wr_en = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zext; wr_en = 1'b1; end
                    OP_LUI:  begin alu_op = ALU_LUI; alu_b = imm_zext; wr_en = 1'b1; end
                    OP_BEQ: begin
                        if (rs_val == rt_val) pc_n = pc_inc + IADDR_W'(imm_sext);
                    end
                    OP_BNE: begin
                        if (rs_val != rt_val) pc_n = pc_inc + IADDR_W'(imm_sext);
                    end
                    OP_J: begin
                        pc_n    = IADDR_W'(target_f);
                        state_n = S_IDLE;
                    end
                    OP_JAL: begin
                        pc_n    = IADDR_W'(target_f);
                        wr_en   = 1'b1;
                        wr_idx  = RIDX_W'(31);
                        wr_data = XLEN'(pc_inc);
                    end
                    OP_LW, OP_SW: begin
                        pc_n         = pc;
                        state_n      = S_MEM;
                        rt_n         = RIDX_W'(rt_f);
                        dmem_req_n   = 1'b1;
                        dmem_we_n    = (op_f == OP_SW);
                        dmem_addr_n  = DADDR_W'(rs_val + imm_sext);
                        dmem_wdata_n = rt_val;
                    end
                    OP_IN: begin
                        pc_n       = pc;
                        state_n    = S_IN_WAIT;
                        rt_n       = RIDX_W'(rt_f);
                        in_ready_n = 1'b1;
                    end
                    OP_OUT: begin
                        pc_n        = pc;
                        state_n     = S_OUT_WAIT;
                        out_valid_n = 1'b1;
                        out_data_n  = rt_val[7:0];
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    dmem_req_n = 1'b0;
                    wr_en      = ~dmem_we;
                    wr_idx     = rt_q;
                    wr_data    = dmem_rdata;
                    pc_n       = pc_inc;
                    state_n    = S_FETCH;
                end
            end
            S_IN_WAIT: begin
                if (in_valid) begin
                    in_ready_n = 1'b0;
                    wr_en      = 1'b1;
                    wr_idx     = rt_q;
                    wr_data    = XLEN'(in_data);
                    pc_n       = pc_inc;
                    state_n    = S_FETCH;
                end
            end
            S_OUT_WAIT: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    pc_n        = pc_inc;
                    state_n     = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase

        running_n = (state_n != S_IDLE);
    end

    // State, pc and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            pc         <= '0;
            rt_q       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            running    <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            rt_q       <= rt_n;
            dmem_req   <= dmem_req_n;
            dmem_we    <= dmem_we_n;
            dmem_addr  <= dmem_addr_n;
            dmem_wdata <= dmem_wdata_n;
            in_ready   <= in_ready_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            running    <= running_n;
        end
    end

    // Register file; r0 is never written so it always reads zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NREG); i++) regs[RIDX_W'(i)] <= '0;
            regs[RIDX_W'(30)] <= SP_INIT;
            regs[RIDX_W'(31)] <= FP_INIT;
        end else if (wr_en && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: directed programs plus random ALU programs against an ISA-level model.
module tb_core_mc;

    localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04, T_BNE = 6'h05;
    localparam logic [5:0] T_ADDI = 6'h08, T_SLTI = 6'h0a, T_ANDI = 6'h0c, T_ORI = 6'h0d, T_LUI = 6'h0f;
    localparam logic [5:0] T_LW = 6'h23, T_SW = 6'h2b, T_IN = 6'h3c, T_OUT = 6'h3d, T_FPU = 6'h11;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2a;

    logic        CLK = 1'b0;
    logic        RST_N, START;
    logic [11:0] imem_addr, pc_dbg, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        in_valid, in_ready, out_valid, out_ready, running;
    logic [7:0]  in_data, out_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom  [4096];
    logic [31:0] dram [4096];
    int          ack_lat = 1;
    int          req_cnt = 0;

    logic [31:0] m_reg [32];
    int          m_pc;
    logic [31:0] m_mem [int];
    logic [7:0]  m_out_q [$];
    logic [7:0]  m_in_byte;

    core_mc dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .running(running), .pc_dbg(pc_dbg)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read instruction ROM
    always @(posedge CLK) imem_rdata <= rom[imem_addr];

    // Data RAM with programmable acknowledge latency (1 = same cycle as request)
    assign dmem_ack   = dmem_req && (req_cnt >= ack_lat - 1);
    assign dmem_rdata = dram[dmem_addr];
    always @(posedge CLK) begin
        if (dmem_req && dmem_ack && dmem_we) dram[dmem_addr] <= dmem_wdata;
        if (dmem_req && !dmem_ack) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
        return {op, 26'(tgt)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return dmem_req;
            1:       return out_valid;
            default: return !running;
        endcase
    endfunction

    // Bounded wait at negedges for a condition; an expired bound is a failed check
    task automatic wait_for(input string tag, input int which);
        int n = 0;
        while (!sig(which) && n < 200) begin
            n++;
            @(negedge CLK);
        end
        chk({tag, ".seen"}, 32'(sig(which)), 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_reg[31] = 32'h40;
        m_pc = 0;
    endtask

    // ISA interpreter: runs from m_pc until a J, returns instructions executed
    task automatic model_run(output int n);
        logic [31:0] ins, a, b, simm, zimm, res;
        int op, fn, rs, rt, rd, sh, tgt, widx, nxt, addr;
        bit done, wr;
        n = 0;
        done = 0;
        while (!done && n < 10000) begin
            ins  = rom[m_pc];
            op   = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
            rd   = int'(ins[15:11]); sh = int'(ins[10:6]);  fn = int'(ins[5:0]);
            tgt  = int'(ins[25:0]);
            a    = m_reg[rs];
            b    = m_reg[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            zimm = {16'h0, ins[15:0]};
            nxt  = (m_pc + 1) & 'hfff;
            wr   = 0; widx = rt; res = 0;
            n++;
            case (op)
                'h00: begin
                    widx = rd;
                    case (fn)
                        'h20: begin res = a + b; wr = 1; end
                        'h22: begin res = a - b; wr = 1; end
                        'h24: begin res = a & b; wr = 1; end
                        'h25: begin res = a | b; wr = 1; end
                        'h27: begin res = ~(a | b); wr = 1; end
                        'h2a: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1; end
                        'h00: begin res = b << sh; wr = 1; end
                        'h02: begin res = b >> sh; wr = 1; end
                        'h08: nxt = int'(a[11:0]);
                        'h09: begin res = 32'((m_pc + 1) & 'hfff); widx = 31; wr = 1; nxt = int'(a[11:0]); end
                        default: ;
                    endcase
                end
                'h08: begin res = a + simm; wr = 1; end
                'h0a: begin res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; wr = 1; end
                'h0c: begin res = a & zimm; wr = 1; end
                'h0d: begin res = a | zimm; wr = 1; end
                'h0f: begin res = zimm * 65536; wr = 1; end
                'h04: if (a == b) nxt = (m_pc + 1 + int'($signed(simm))) & 'hfff;
                'h05: if (a != b) nxt = (m_pc + 1 + int'($signed(simm))) & 'hfff;
                'h02: begin nxt = tgt & 'hfff; done = 1; end
                'h03: begin res = 32'((m_pc + 1) & 'hfff); widx = 31; wr = 1; nxt = tgt & 'hfff; end
                'h23: begin
                    addr = int'((a + simm) & 32'hfff);
                    res  = m_mem.exists(addr) ? m_mem[addr] : 32'h0;
                    wr   = 1;
                end
                'h2b: begin addr = int'((a + simm) & 32'hfff); m_mem[addr] = b; end
                'h3c: begin res = {24'h0, m_in_byte}; wr = 1; end
                'h3d: m_out_q.push_back(b[7:0]);
                default: ;
            endcase
            if (wr && widx != 0) m_reg[widx] = res;
            m_pc = nxt;
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".pc"}, 32'(pc_dbg), 32'(m_pc));
        for (int i = 0; i < 32; i++) chk($sformatf("%s.r%0d", tag, i), dut.regs[i], m_reg[i]);
    endtask

    // Start the core, optionally holding START for several cycles, and count running cycles
    task automatic run_prog(input string tag, input int hold, output int cyc);
        @(negedge CLK);
        START = 1'b1;
        cyc = 0;
        @(negedge CLK);
        while (running && cyc < 5000) begin
            cyc++;
            if (cyc >= hold) START = 1'b0;
            @(negedge CLK);
        end
        START = 1'b0;
        chk({tag, ".idle"}, 32'(running), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr(input int k, input int last);
        int sel = $urandom_range(0, 15);
        int rd  = $urandom_range(0, 31);
        int rs  = $urandom_range(0, 31);
        int rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom_range(0, 31);
        int imm = int'($urandom_range(0, 65535));
        int br  = $urandom_range(0, last - k - 1);
        case (sel)
            0:  return enc_i(T_ADDI, rt, rs, imm);
            1:  return enc_i(T_SLTI, rt, rs, imm);
            2:  return enc_i(T_ANDI, rt, rs, imm);
            3:  return enc_i(T_ORI,  rt, rs, imm);
            4:  return enc_i(T_LUI,  rt, 0,  imm);
            5:  return enc_r(F_ADD, rd, rs, rt, 0);
            6:  return enc_r(F_SUB, rd, rs, rt, 0);
            7:  return enc_r(F_AND, rd, rs, rt, 0);
            8:  return enc_r(F_OR,  rd, rs, rt, 0);
            9:  return enc_r(F_NOR, rd, rs, rt, 0);
            10: return enc_r(F_SLT, rd, rs, rt, 0);
            11: return enc_r(($urandom_range(0, 1) == 1) ? F_SLL : F_SRL, rd, 0, rt, $urandom_range(0, 31));
            12: return enc_i(T_BEQ, rt, rs, br);
            13: return enc_i(T_BNE, rt, rs, br);
            14: return {T_FPU, 26'($urandom)};
            default: return enc_r(6'h3f, rd, rs, rt, 0);
        endcase
    endfunction

    initial begin
        int cyc, n, cnt;
        int last;
        logic [11:0] pc0;
        logic [7:0]  out_seen;

        for (int i = 0; i < 4096; i++) rom[i] = 32'h0;
        // Arithmetic, r0, branches, JAL/JALR
        rom[0]  = enc_i(T_ADDI, 1, 0, 5);
        rom[1]  = enc_i(T_ADDI, 2, 0, -3);
        rom[2]  = enc_r(F_SUB, 3, 1, 2, 0);
        rom[3]  = enc_r(F_SLT, 4, 2, 1, 0);
        rom[4]  = enc_i(T_ADDI, 0, 0, 7);
        rom[5]  = enc_i(T_BEQ, 0, 0, 2);
        rom[6]  = enc_i(T_ADDI, 9, 0, 1);
        rom[7]  = enc_i(T_ADDI, 9, 0, 2);
        rom[8]  = enc_i(T_BNE, 1, 1, 5);
        rom[9]  = enc_j(T_JAL, 12);
        rom[10] = enc_i(T_ADDI, 10, 0, 'h77);
        rom[11] = enc_j(T_J, 'h10);
        rom[12] = enc_i(T_ADDI, 11, 0, 11);
        rom[13] = enc_r(F_JALR, 0, 31, 0, 0);
        // Memory and byte IO
        rom['h10] = enc_i(T_ADDI, 31, 0, 'h40);
        rom['h11] = enc_i(T_ADDI, 1, 0, 'h1234);
        rom['h12] = enc_i(T_SW, 1, 31, 0);
        rom['h13] = enc_i(T_LW, 5, 31, 0);
        rom['h14] = enc_i(T_ADDI, 6, 0, 'hA5);
        rom['h15] = enc_i(T_OUT, 6, 0, 0);
        rom['h16] = enc_i(T_IN, 7, 0, 0);
        rom['h17] = enc_j(T_J, 'h20);
        // Reset during an unacknowledged load
        rom['h20] = enc_i(T_ADDI, 8, 0, 99);
        rom['h21] = enc_i(T_LW, 9, 0, 4);
        rom['h22] = enc_j(T_J, 'h20);

        RST_N = 1'b0; START = 1'b0; in_valid = 1'b0; in_data = 8'h3C;
        out_ready = 1'b0; m_in_byte = 8'h3C;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst.pc", 32'(pc_dbg), 32'h0);
        chk("rst.running", 32'(running), 32'h0);
        chk("rst.dmem_req", 32'(dmem_req), 32'h0);
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_data", 32'(out_data), 32'h0);
        chk("rst.r30", dut.regs[30], 32'h0);
        chk("rst.r31", dut.regs[31], 32'h40);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle.no_start", 32'(running), 32'h0);

        // Arithmetic / branch program: 12 instructions, 2 cycles each
        run_prog("p0", 1, cyc);
        model_run(n);
        chk("p0.cycles", 32'(cyc), 32'(2 * n));
        chk("p0.cycles_const", 32'(cyc), 32'd24);
        chk("p0.r3", dut.regs[3], 32'd8);
        chk("p0.r4", dut.regs[4], 32'd1);
        chk("p0.r0", dut.regs[0], 32'd0);
        chk("p0.r9", dut.regs[9], 32'd0);
        chk("p0.r31", dut.regs[31], 32'd14);
        chk("p0.j_pc", 32'(pc_dbg), 32'h10);
        cmp_all("p0");

        // Memory with 4-cycle then same-cycle ack, OUT backpressure, IN
        ack_lat = 4;
        in_valid = 1'b1;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("p1.fetch_addr", 32'(imem_addr), 32'h10);
        wait_for("p1.sw", 0);
        chk("p1.sw_addr", 32'(dmem_addr), 32'h40);
        chk("p1.sw_we", 32'(dmem_we), 32'd1);
        chk("p1.sw_wdata", dmem_wdata, 32'h1234);
        cnt = 0;
        while (dmem_req && cnt < 100) begin
            cnt++;
            @(negedge CLK);
        end
        chk("p1.sw_req_cycles", 32'(cnt), 32'd4);
        ack_lat = 1;
        wait_for("p1.lw", 0);
        chk("p1.lw_we", 32'(dmem_we), 32'd0);
        chk("p1.lw_addr", 32'(dmem_addr), 32'h40);
        cnt = 0;
        while (dmem_req && cnt < 100) begin
            cnt++;
            @(negedge CLK);
        end
        chk("p1.lw_req_cycles", 32'(cnt), 32'd1);
        wait_for("p1.out", 1);
        pc0 = pc_dbg;
        out_seen = out_data;
        chk("p1.out_pc", 32'(pc0), 32'h15);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p1.out_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("p1.out_data%0d", i), 32'(out_data), 32'hA5);
            chk($sformatf("p1.out_pc%0d", i), 32'(pc_dbg), 32'(pc0));
            @(negedge CLK);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("p1.out_drop", 32'(out_valid), 32'd0);
        chk("p1.out_pc_adv", 32'(pc_dbg), 32'(pc0 + 12'd1));
        wait_for("p1.done", 2);
        model_run(n);
        chk("p1.r5", dut.regs[5], 32'h1234);
        chk("p1.r7", dut.regs[7], 32'h3C);
        chk("p1.out_byte", 32'(out_seen), 32'(m_out_q.size() > 0 ? m_out_q[0] : 8'h00));
        cmp_all("p1");

        // Reset while a load waits forever for ack
        ack_lat = 1000;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_for("p2.lw", 0);
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("p2.running", 32'(running), 32'd0);
        chk("p2.dmem_req", 32'(dmem_req), 32'd0);
        chk("p2.pc", 32'(pc_dbg), 32'd0);
        chk("p2.r8", dut.regs[8], 32'd0);
        chk("p2.r9", dut.regs[9], 32'd0);
        chk("p2.r31", dut.regs[31], 32'h40);
        @(negedge CLK);
        RST_N = 1'b1;
        ack_lat = 1;
        model_reset();

        // Random ALU/branch programs at 0x40, START held a few cycles
        rom[0] = enc_j(T_J, 'h40);
        run_prog("jump40", 1, cyc);
        model_run(n);
        chk("jump40.cycles", 32'(cyc), 32'd2);
        cmp_all("jump40");
        for (int it = 0; it < 20; it++) begin
            last = $urandom_range(4, 12);
            for (int k = 0; k < last; k++) rom['h40 + k] = rand_instr(k, last);
            rom['h40 + last] = enc_j(T_J, 'h40);
            run_prog($sformatf("rnd%0d", it), 3, cyc);
            model_run(n);
            chk($sformatf("rnd%0d.cycles", it), 32'(cyc), 32'(2 * n));
            cmp_all($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
